tff_updown_counter: RTL and testbench

Synchronous modulo-N up/down counter built as a bank of toggle flip-flops plus the toggle-enable logic that drives them. It sits directly upstream of our T flip-flop stages: it computes the per-bit toggle vector (`t_vec`) that those stages consume and holds the resulting count. It adds parallel load, terminal-count detection, a wrap pulse and a saturating wrap counter, so the toggle bank can serve as a general event counter.

---
 rtl/tff_updown_counter.sv | 88 ++++++++
 tb/tb_tff_updown_counter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tff_updown_counter.sv
// tff_updown_counter: modulo-MODULUS up/down counter built from a bank of
// toggle flip-flops. The next count is turned into a per-bit toggle vector
// (t_vec) that the T stages use. The block also provides clamped parallel
// load, terminal-count detection, a wrap pulse and a saturating wrap counter.
module tff_updown_counter #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MODULUS = 16,
  parameter int unsigned WCNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              up,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic              clr,
  output logic [WIDTH-1:0]  q,
  output logic [WIDTH-1:0]  t_vec,
  output logic              tc,
  output logic              wrap,
  output logic [WCNT_W-1:0] wrap_cnt
);

  // Largest legal count value. Computing the range check one bit wider
  // means MODULUS = 2**WIDTH does not overflow.
  localparam logic [WIDTH-1:0] TOP     = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0]  q_q;
  logic [WIDTH-1:0]  q_d;
  logic [WIDTH-1:0]  t_vec_d;
  logic              tc_d;
  logic              at_top;
  logic              at_zero;
  logic              wrap_q;
  logic [WCNT_W-1:0] wrap_cnt_q;
  logic [WCNT_W-1:0] wrap_cnt_d;

  // Next-count selection (load > count > hold), toggle vector and terminal count
  always_comb begin
    at_top  = (q_q == TOP);
    at_zero = (q_q == '0);
    q_d     = q_q;
    if (load) begin
      q_d = ({1'b0, load_val} >= MOD_EXT) ? TOP : load_val;
    end else if (en) begin
      if (up) begin
        q_d = at_top ? '0 : q_q + WIDTH'(1);
      end else begin
        q_d = at_zero ? TOP : q_q - WIDTH'(1);
      end
    end
    // The T bank only sees the difference between the current and next count,
    // so load, count and hold all reach q through the same toggle path.
    t_vec_d = q_q ^ q_d;
    tc_d    = en & ~load & ((up & at_top) | (~up & at_zero));
  end

  // Wrap counter next state: clear wins over increment, increment saturates
  always_comb begin
    wrap_cnt_d = wrap_cnt_q;
    if (clr) begin
      wrap_cnt_d = '0;
    end else if (tc_d && (wrap_cnt_q != '1)) begin
      wrap_cnt_d = wrap_cnt_q + WCNT_W'(1);
    end
  end

  // Toggle flip-flop bank plus wrap pulse and wrap counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q        <= '0;
      wrap_q     <= 1'b0;
      wrap_cnt_q <= '0;
    end else begin
      q_q        <= q_q ^ t_vec_d;
      wrap_q     <= tc_d;
      wrap_cnt_q <= wrap_cnt_d;
    end
  end

  assign q        = q_q;
  assign t_vec    = t_vec_d;
  assign tc       = tc_d;
  assign wrap     = wrap_q;
  assign wrap_cnt = wrap_cnt_q;

endmodule

// File: tb/tb_tff_updown_counter.sv
// Scoreboard bench for tff_updown_counter. Three instances cover the
// configurations of interest: WIDTH=4/MODULUS=16, WIDTH=4/MODULUS=10 and
// WIDTH=2/MODULUS=2/WCNT_W=2. Stimulus pushes hand-computed expectations
// tagged with a sample slot; the monitor pops and compares them.
module tb_tff_updown_counter;

  localparam int SQ = 0, STV = 1, STC = 2, SWR = 3, SWC = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0, up = 1'b0, load = 1'b0, clr = 1'b0;
  logic [3:0] load_val = '0;

  logic [3:0] q16, tv16, q10, tv10;
  logic [1:0] q2, tv2, wc2;
  logic [7:0] wc16, wc10;
  logic       tc16, wr16, tc10, wr10, tc2, wr2;

  tff_updown_counter #(.WIDTH(4), .MODULUS(16), .WCNT_W(8)) u16 (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .load_val(load_val),
    .clr(clr), .q(q16), .t_vec(tv16), .tc(tc16), .wrap(wr16), .wrap_cnt(wc16));

  tff_updown_counter #(.WIDTH(4), .MODULUS(10), .WCNT_W(8)) u10 (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .load_val(load_val),
    .clr(clr), .q(q10), .t_vec(tv10), .tc(tc10), .wrap(wr10), .wrap_cnt(wc10));

  tff_updown_counter #(.WIDTH(2), .MODULUS(2), .WCNT_W(2)) u2 (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .load_val(load_val[1:0]),
    .clr(clr), .q(q2), .t_vec(tv2), .tc(tc2), .wrap(wr2), .wrap_cnt(wc2));

  always #5 clk = ~clk;

  typedef struct {
    int    key;
    int    inst;
    int    sig;
    int    exp;
    string name;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   async_req = 0;
  event async_ev;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] get_act(int inst, int sig);
    logic [31:0] r;
    r = 'x;
    case (inst)
      0: case (sig)
           SQ: r = 32'(q16);  STV: r = 32'(tv16); STC: r = 32'(tc16);
           SWR: r = 32'(wr16); SWC: r = 32'(wc16); default: r = 'x;
         endcase
      1: case (sig)
           SQ: r = 32'(q10);  STV: r = 32'(tv10); STC: r = 32'(tc10);
           SWR: r = 32'(wr10); SWC: r = 32'(wc10); default: r = 'x;
         endcase
      default: case (sig)
           SQ: r = 32'(q2);  STV: r = 32'(tv2); STC: r = 32'(tc2);
           SWR: r = 32'(wr2); SWC: r = 32'(wc2); default: r = 'x;
         endcase
    endcase
    return r;
  endfunction

  // Expectation for the mid-cycle sample of the current cycle
  function automatic void expect_now(int inst, int sig, int val, string nm);
    exp_t e;
    e.key = 2 * cyc; e.inst = inst; e.sig = sig; e.exp = val; e.name = nm;
    sbq.push_back(e);
  endfunction

  // Expectation for an out-of-band sample taken between clock edges
  function automatic void expect_async(int inst, int sig, int val, string nm);
    exp_t e;
    e.key = 2 * cyc + 1; e.inst = inst; e.sig = sig; e.exp = val; e.name = nm;
    sbq.push_back(e);
  endfunction

  // Monitor: at each falling edge (or an async sample request) compare every
  // expectation due in this slot; anything older than the slot was missed.
  int async_seen = 0;
  always @(negedge clk or async_ev) begin : monitor
    int key;
    logic [31:0] act;
    if (async_req != async_seen) begin
      key = 2 * cyc + 1;
      async_seen = async_req;
    end else begin
      key = 2 * cyc;
    end
    for (int i = sbq.size() - 1; i >= 0; i--) begin
      if (sbq[i].key <= key) begin
        n_cmp++;
        act = get_act(sbq[i].inst, sbq[i].sig);
        if (sbq[i].key < key) begin
          n_bad++;
          $display("FAIL %s inst%0d: sample slot %0d missed (now %0d), expected %0d",
                   sbq[i].name, sbq[i].inst, sbq[i].key, key, sbq[i].exp);
        end else if (act !== 32'(sbq[i].exp)) begin
          n_bad++;
          $display("FAIL %s inst%0d cyc %0d: got %0d expected %0d",
                   sbq[i].name, sbq[i].inst, cyc, act, sbq[i].exp);
        end
        sbq.delete(i);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(int inst);
    rst_n = 1'b0; en = 1'b0; up = 1'b0; load = 1'b0; clr = 1'b0; load_val = '0;
    tick();
    expect_now(inst, SQ, 0, "rst_q");
    expect_now(inst, SWR, 0, "rst_wrap");
    expect_now(inst, SWC, 0, "rst_wcnt");
    rst_n = 1'b1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    tick();
    tick();

    // Full-range up count, MODULUS=16
    do_reset(0);
    en = 1'b1; up = 1'b1;
    for (int k = 0; k <= 17; k++) begin
      expect_now(0, SQ, k % 16, "up16_q");
      expect_now(0, STV, (k % 16) ^ ((k + 1) % 16), "up16_tvec");
      expect_now(0, STC, (k % 16 == 15) ? 1 : 0, "up16_tc");
      expect_now(0, SWR, (k == 16) ? 1 : 0, "up16_wrap");
      expect_now(0, SWC, (k >= 16) ? 1 : 0, "up16_wcnt");
      tick();
    end

    // Down count from 0 with MODULUS=10, then clamped load and load-no-wrap
    do_reset(1);
    en = 1'b1; up = 1'b0;
    expect_now(1, SQ, 0, "dn10_q0"); expect_now(1, STC, 1, "dn10_tc0");
    expect_now(1, STV, 9, "dn10_tv0");
    tick();
    expect_now(1, SQ, 9, "dn10_q1"); expect_now(1, STC, 0, "dn10_tc1");
    expect_now(1, SWR, 1, "dn10_wr1"); expect_now(1, SWC, 1, "dn10_wc1");
    expect_now(1, STV, 1, "dn10_tv1");
    tick();
    expect_now(1, SQ, 8, "dn10_q2"); expect_now(1, SWR, 0, "dn10_wr2");
    expect_now(1, STC, 0, "dn10_tc2");
    tick();
    expect_now(1, SQ, 7, "dn10_q3"); expect_now(1, SWR, 0, "dn10_wr3");
    load = 1'b1; load_val = 4'd12; en = 1'b1; up = 1'b1;
    expect_now(1, STV, 14, "ld_clamp_tv"); expect_now(1, STC, 0, "ld_clamp_tc");
    tick();
    expect_now(1, SQ, 9, "ld_clamp_q"); expect_now(1, SWR, 0, "ld_clamp_wr");
    expect_now(1, SWC, 1, "ld_clamp_wc");
    load = 1'b0; en = 1'b1; up = 1'b1;
    expect_now(1, STC, 1, "ld_up_tc"); expect_now(1, STV, 9, "ld_up_tv");
    tick();
    expect_now(1, SQ, 0, "ld_up_q"); expect_now(1, SWR, 1, "ld_up_wr");
    expect_now(1, SWC, 2, "ld_up_wc");
    load = 1'b1; load_val = 4'd9; en = 1'b1; up = 1'b0;
    expect_now(1, STC, 0, "ld_cross_tc"); expect_now(1, STV, 9, "ld_cross_tv");
    tick();
    expect_now(1, SQ, 9, "ld_cross_q"); expect_now(1, SWR, 0, "ld_cross_wr");
    expect_now(1, SWC, 2, "ld_cross_wc");
    expect_now(1, STV, 0, "ld_same_tv"); expect_now(1, STC, 0, "ld_same_tc");
    tick();
    expect_now(1, SQ, 9, "ld_same_q");
    load = 1'b0; en = 1'b0;
    tick();

    // Back-to-back wraps in alternating directions, saturation, clear
    do_reset(2);
    en = 1'b1; up = 1'b0;
    expect_now(2, SQ, 0, "m2_q0"); expect_now(2, STC, 1, "m2_tc0");
    expect_now(2, STV, 1, "m2_tv0");
    tick();
    expect_now(2, SQ, 1, "m2_q1"); expect_now(2, SWR, 1, "m2_wr1");
    expect_now(2, SWC, 1, "m2_wc1");
    up = 1'b1;
    expect_now(2, STC, 1, "m2_tc1");
    tick();
    expect_now(2, SQ, 0, "m2_q2"); expect_now(2, SWR, 1, "m2_wr2");
    expect_now(2, SWC, 2, "m2_wc2");
    up = 1'b0;
    tick();
    expect_now(2, SQ, 1, "m2_q3"); expect_now(2, SWR, 1, "m2_wr3");
    expect_now(2, SWC, 3, "m2_wc3");
    up = 1'b1;
    tick();
    expect_now(2, SQ, 0, "m2_q4"); expect_now(2, SWR, 1, "m2_wr4");
    expect_now(2, SWC, 3, "m2_wc_sat");
    up = 1'b0; clr = 1'b1;
    expect_now(2, STC, 1, "m2_tc4");
    tick();
    expect_now(2, SQ, 1, "m2_q5"); expect_now(2, SWR, 1, "clr_wr");
    expect_now(2, SWC, 0, "clr_wc");
    clr = 1'b0; en = 1'b0;
    expect_now(2, STC, 0, "m2_tc5"); expect_now(2, STV, 0, "m2_tv5");
    tick();
    expect_now(2, SQ, 1, "m2_q6"); expect_now(2, SWR, 0, "m2_wr6");
    expect_now(2, SWC, 0, "m2_wc6");
    tick();

    // Asynchronous reset mid-count at q=5, then restart and idle hold
    do_reset(0);
    en = 1'b1; up = 1'b1;
    for (int k = 0; k < 5; k++) begin
      expect_now(0, SQ, k, "pre_arst_q");
      tick();
    end
    expect_now(0, SQ, 5, "arst_q5");
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    expect_async(0, SQ, 0, "arst_q");
    expect_async(0, SWR, 0, "arst_wr");
    expect_async(0, SWC, 0, "arst_wc");
    async_req++;
    ->async_ev;
    tick();
    expect_now(0, SQ, 0, "arst_hold_q");
    rst_n = 1'b1;
    tick();
    expect_now(0, SQ, 1, "arst_first_q");
    expect_now(0, SWR, 0, "arst_first_wr");
    en = 1'b0; load = 1'b0; load_val = 4'd12; up = 1'b1;
    for (int k = 0; k < 5; k++) begin
      expect_now(0, STV, 0, "idle_tv");
      expect_now(0, STC, 0, "idle_tc");
      tick();
      expect_now(0, SQ, 1, "idle_q");
    end
    tick();
    tick();

    for (int i = 0; i < sbq.size(); i++) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s inst%0d: expectation never sampled, expected %0d",
               sbq[i].name, sbq[i].inst, sbq[i].exp);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
